multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore/Mealy control FSM that sequences a multi-cycle RV32I-subset datapath: shared ALU, shared instruction/data memory port, IR, register file and immediate generator. It decodes opcode/funct3 from the IR and issues per-cycle mux selects and write enables. It waits on a memory-ready handshake, guards the wait with a timeout, counts retired instructions, and traps on illegal opcodes.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
MEM_TIMEOUT, 255, max cycles any memory state may wait for mem_ready before bus error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  IR[6:0]
funct3  input  3  IR[14:12]
zero  input  1  ALU zero flag (combinational, current cycle)
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  load PC from result bus
ir_write  output  1  load IR (and old-PC register) from memory read data
adr_src  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
reg_write  output  1  register-file write enable
alu_src_a  output  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  output  2  00=rs2, 01=imm, 10=constant 4
alu_op  output  2  00=add, 01=subtract, 10=funct-decoded
result_src  output  2  00=ALUOut register, 01=memory data register, 10=ALU result direct
illegal  output  1  sticky, illegal opcode trapped
bus_err  output  1  sticky, memory timeout trapped
instr_count  output  CNT_WIDTH  retired instructions
state  output  4  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JALR=10, JAL=11, TRAP=15. Other codes go to FETCH.
- Reset (async, any state, including mid-wait): state=FETCH, instr_count=0, illegal=0, bus_err=0, wait counter=0. Outputs then take FETCH values.
- All outputs default to 0 unless listed for the state.
- FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - pc_write=ir_write=mem_ready (Mealy).
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other -> TRAP, setting illegal
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. opcode 0000011 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held until mem_ready -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00 -> FETCH.
  - pc_write = zero when funct3=000, ~zero when funct3=001, 0 for any other funct3 (not-taken, not illegal).
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00 (target rs1+imm into ALUOut) -> JAL.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (link oldPC+4 written to rd).
- TRAP: every enable and strobe 0. Stays until reset; no further fetches.
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle spent in one of these states with mem_ready=0.
  - Reaching MEM_TIMEOUT with mem_ready still 0 -> TRAP, bus_err=1.
  - mem_ready in the same cycle as the timeout wins: the access completes normally.
- instr_count: +1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. Wraps modulo 2^CNT_WIDTH. Never increments in TRAP.
- Latency with mem_ready tied 1:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles

Test Plan:
- Reset asserted mid-MEMREAD, mem_ready=0 -> next sampled state=0, mem_read=1, instr_count=0, illegal=0, bus_err=0.
- opcode=0010011 (addi 0x00500093), mem_ready=1 -> states 0,1,7,8,0; reg_write=1 only in state 8; alu_op=10 in state 7; instr_count 0->1.
- opcode=0000011, mem_ready low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; mem_read=1 and adr_src=1 throughout state 3; result_src=01 in state 4.
- opcode=1100011: funct3=000/zero=1 -> pc_write=1 in state 9; funct3=001/zero=1 -> pc_write=0; funct3=000/zero=0 -> pc_write=0; each takes 3 cycles.
- opcode=1100111 -> states 0,1,10,11,8,0; pc_write=1 in state 11 with result_src=00; reg_write=1 in state 8.
- opcode=0000000 -> TRAP (15), illegal=1 stays through 20 cycles. Separately, MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> TRAP after 4 waits, bus_err=1, instr_count unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle RV32I-subset datapath: per-state mux selects and
// strobes, memory handshake with timeout, retired-instruction counter and traps.
`timescale 1ns/1ps
module multicycle_control #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_instr_count;
  logic                 r_illegal;
  logic                 r_bus_err;
  logic                 w_mem_state;
  logic                 w_mem_wait;
  logic                 w_timeout;
  logic                 w_retire;
  logic                 w_branch_taken;
  logic                 w_enter_wait;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_mem_wait  = w_mem_state && !mem_ready;
  // A ready arriving on the last allowed cycle still completes the access.
  assign w_timeout   = w_mem_wait && (r_wait_cnt == WAIT_LAST);
  assign w_enter_wait = (w_next != r_state) &&
                        ((w_next == S_FETCH) || (w_next == S_MEMREAD) || (w_next == S_MEMWRITE));

  always_comb begin
    w_branch_taken = 1'b0;
    case (funct3)
      3'b000:  w_branch_taken = zero;
      3'b001:  w_branch_taken = ~zero;
      default: w_branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    w_retire   = 1'b0;
    w_next     = r_state;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = w_branch_taken;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = S_JAL;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= 8'd0;
      r_instr_count <= '0;
      r_illegal     <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_wait)    r_wait_cnt <= 8'd0;
      else if (w_mem_wait) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_retire)        r_instr_count <= r_instr_count + CNT_WIDTH'(1);
      if ((r_state == S_DECODE) && (w_next == S_TRAP)) r_illegal <= 1'b1;
      if (w_timeout)       r_bus_err <= 1'b1;
    end
  end

  assign illegal     = r_illegal;
  assign bus_err     = r_bus_err;
  assign instr_count = r_instr_count;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction path model with a per-cycle
// output checker, plus literal path/count/trap checks and a short-timeout instance.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4;
  localparam logic [3:0] SMW = 4'd5, SER = 4'd6, SEI = 4'd7, SAW = 4'd8, SBR = 4'd9;
  localparam logic [3:0] SJR = 4'd10, SJ = 4'd11, ST = 4'd15;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BAD = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        reset, zero, mem_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal, bus_err;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instr_count;
  logic [3:0]  state;

  multicycle_control #(.CNT_WIDTH(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count), .state(state)
  );

  // short-timeout instance
  logic        b_reset, b_zero, b_mr;
  logic [6:0]  b_op;
  logic [2:0]  b_f3;
  logic        b_pcw, b_irw, b_adr, b_mrd, b_mwr, b_rw, b_ill, b_be;
  logic [1:0]  b_a, b_b, b_aop, b_rs;
  logic [7:0]  b_cnt;
  logic [3:0]  b_state;

  multicycle_control #(.CNT_WIDTH(8), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(b_reset), .opcode(b_op), .funct3(b_f3), .zero(b_zero),
    .mem_ready(b_mr), .pc_write(b_pcw), .ir_write(b_irw), .adr_src(b_adr),
    .mem_read(b_mrd), .mem_write(b_mwr), .reg_write(b_rw),
    .alu_src_a(b_a), .alu_src_b(b_b), .alu_op(b_aop), .result_src(b_rs),
    .illegal(b_ill), .bus_err(b_be), .instr_count(b_cnt), .state(b_state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [31:0] cnt;
    logic        ill;
    logic        be;
  } rec_t;

  rec_t        exp_q[$];
  logic [3:0]  hist[$];
  rec_t        chk_e;
  int          tests = 0;
  int          fails = 0;
  logic        br_pcw;
  logic [31:0] m_cnt;
  logic        m_ill, m_be;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic        cur_z;

  wire logic [13:0] w_ctl = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                             alu_src_a, alu_src_b, alu_op, result_src};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Control word each state must present, read off the per-state output rules.
  function automatic logic [13:0] exp_ctl(input logic [3:0] st, input logic mr,
                                          input logic [2:0] f3, input logic z);
    logic pcw, irw, adr, mrd, mwr, rw;
    logic [1:0] a, b, op, rs;
    pcw = 0; irw = 0; adr = 0; mrd = 0; mwr = 0; rw = 0;
    a = 2'b00; b = 2'b00; op = 2'b00; rs = 2'b00;
    case (st)
      SF:   begin mrd = 1; b = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
      SD:   begin a = 2'b01; b = 2'b01; end
      SMA:  begin a = 2'b10; b = 2'b01; end
      SMR:  begin adr = 1; mrd = 1; end
      SMWB: begin rs = 2'b01; rw = 1; end
      SMW:  begin adr = 1; mwr = 1; end
      SER:  begin a = 2'b10; op = 2'b10; end
      SEI:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      SAW:  rw = 1;
      SBR:  begin a = 2'b10; op = 2'b01; pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0); end
      SJR:  begin a = 2'b10; b = 2'b01; end
      SJ:   begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rw, a, b, op, rs};
  endfunction

  task automatic step(input logic [3:0] st, input logic mr);
    rec_t r;
    @(negedge clk);
    opcode = cur_op; funct3 = cur_f3; zero = cur_z; mem_ready = mr;
    r.st  = st;
    r.ctl = exp_ctl(st, mr, cur_f3, cur_z);
    r.cnt = m_cnt;
    r.ill = m_ill;
    r.be  = m_be;
    exp_q.push_back(r);
  endtask

  // Expands one instruction into its cycle-by-cycle state path.
  task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fw, input int mw);
    #3;
    hist.delete();
    cur_op = op; cur_f3 = f3; cur_z = z;
    for (int i = 0; i < fw; i++) step(SF, 1'b0);
    step(SF, 1'b1);
    step(SD, 1'b0);
    case (op)
      OP_LOAD: begin
        step(SMA, 1'b0);
        for (int i = 0; i < mw; i++) step(SMR, 1'b0);
        step(SMR, 1'b1); step(SMWB, 1'b0); m_cnt++;
      end
      OP_STORE: begin
        step(SMA, 1'b0);
        for (int i = 0; i < mw; i++) step(SMW, 1'b0);
        step(SMW, 1'b1); m_cnt++;
      end
      OP_R:    begin step(SER, 1'b0); step(SAW, 1'b0); m_cnt++; end
      OP_I:    begin step(SEI, 1'b0); step(SAW, 1'b0); m_cnt++; end
      OP_BR:   begin step(SBR, 1'b0); m_cnt++; end
      OP_JAL:  begin step(SJ, 1'b0); step(SAW, 1'b0); m_cnt++; end
      OP_JALR: begin step(SJR, 1'b0); step(SJ, 1'b0); step(SAW, 1'b0); m_cnt++; end
      default: begin m_ill = 1'b1; step(ST, 1'b0); end
    endcase
  endtask

  task automatic check_path(input string name, input logic [63:0] want, input int len);
    logic [63:0] got;
    #3;
    got = '0;
    foreach (hist[k]) got = (got << 4) | 64'(hist[k]);
    chk(name, (got << 8) | 64'(hist.size()), (want << 8) | 64'(len));
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      chk_e = exp_q.pop_front();
      hist.push_back(state);
      if (state == SBR) br_pcw = pc_write;
      chk("state",   64'(state),       64'(chk_e.st));
      chk("ctl",     64'(w_ctl),       64'(chk_e.ctl));
      chk("count",   64'(instr_count), 64'(chk_e.cnt));
      chk("illegal", 64'(illegal),     64'(chk_e.ill));
      chk("bus_err", 64'(bus_err),     64'(chk_e.be));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; opcode = '0; funct3 = '0; zero = 0; mem_ready = 0;
    b_reset = 1; b_op = OP_I; b_f3 = '0; b_zero = 0; b_mr = 0;
    cur_op = '0; cur_f3 = '0; cur_z = 0;
    m_cnt = '0; m_ill = 0; m_be = 0; br_pcw = 0;

    #12;
    chk("reset state",   64'(state), 64'(0));
    chk("reset mem_read", 64'(mem_read), 64'(1));
    chk("reset count",   64'(instr_count), 64'(0));
    chk("reset flags",   64'({illegal, bus_err}), 64'(0));
    @(negedge clk); reset = 0;

    add_instr(OP_I, 3'b000, 1'b0, 0, 0);          // addi x1,x0,5
    check_path("addi path", 64'h0178, 4);
    @(posedge clk); #1;
    chk("addi count", 64'(instr_count), 64'(1));

    add_instr(OP_R, 3'b000, 1'b0, 2, 0);
    add_instr(OP_LOAD, 3'b010, 1'b0, 0, 3);
    check_path("load path", 64'h01233334, 8);
    add_instr(OP_STORE, 3'b010, 1'b0, 1, 1);

    add_instr(OP_BR, 3'b000, 1'b1, 0, 0);
    check_path("beq taken path", 64'h019, 3);
    chk("beq taken pc_write", 64'(br_pcw), 64'(1));
    add_instr(OP_BR, 3'b001, 1'b1, 0, 0);
    check_path("bne nt path", 64'h019, 3);
    chk("bne nt pc_write", 64'(br_pcw), 64'(0));
    add_instr(OP_BR, 3'b000, 1'b0, 0, 0);
    check_path("beq nt path", 64'h019, 3);
    chk("beq nt pc_write", 64'(br_pcw), 64'(0));
    add_instr(OP_BR, 3'b001, 1'b0, 0, 0);
    add_instr(OP_BR, 3'b010, 1'b1, 0, 0);

    add_instr(OP_JALR, 3'b000, 1'b0, 0, 0);
    check_path("jalr path", 64'h01AB8, 5);
    add_instr(OP_JAL, 3'b000, 1'b0, 0, 0);
    check_path("jal path", 64'h01B8, 4);
    @(posedge clk); #1;
    chk("retired count", 64'(instr_count), 64'(11));

    // async reset while waiting in MEMREAD
    #3;
    cur_op = OP_LOAD; cur_f3 = 3'b010; cur_z = 0;
    step(SF, 1'b1); step(SD, 1'b0); step(SMA, 1'b0); step(SMR, 1'b0); step(SMR, 1'b0);
    #3;
    reset = 1;
    #1;
    chk("midwait reset state",    64'(state), 64'(0));
    chk("midwait reset mem_read", 64'(mem_read), 64'(1));
    chk("midwait reset count",    64'(instr_count), 64'(0));
    chk("midwait reset flags",    64'({illegal, bus_err}), 64'(0));
    m_cnt = '0; m_ill = 0; m_be = 0;
    @(negedge clk); reset = 0;

    add_instr(OP_I, 3'b000, 1'b0, 0, 0);
    add_instr(OP_BAD, 3'b000, 1'b0, 0, 0);
    check_path("illegal path", 64'h01F, 3);
    for (int i = 0; i < 20; i++) step(ST, 1'(i & 1));
    #3;
    chk("trap sticky illegal", 64'(illegal), 64'(1));
    chk("trap state",          64'(state), 64'(15));
    chk("trap count frozen",   64'(instr_count), 64'(1));
    chk("queue drained",       64'(exp_q.size()), 64'(0));
    reset = 1;
    #1;
    chk("illegal cleared", 64'(illegal), 64'(0));
    @(negedge clk); reset = 0;

    // fetch timeout with MEM_TIMEOUT=4
    b_mr = 0; b_reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("to wait state", 64'({b_state, b_be}), 64'({SF, 1'b0}));
    end
    @(posedge clk); #1;
    chk("to trap state", 64'(b_state), 64'(15));
    chk("to bus_err",    64'(b_be), 64'(1));
    chk("to count",      64'(b_cnt), 64'(0));
    chk("to no fetch",   64'({b_mrd, b_pcw, b_irw}), 64'(0));

    // ready on the timeout cycle completes the fetch
    b_reset = 1;
    #1;
    chk("to reset bus_err", 64'(b_be), 64'(0));
    @(negedge clk); b_reset = 0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk); b_mr = 1;
    @(posedge clk); #1;
    chk("to ready wins state", 64'(b_state), 64'(1));
    chk("to ready wins flag",  64'(b_be), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
